stall_consumer: RTL
===================

STALL_CONSUMER -- requirements
Module: stall_consumer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, entries per channel buffer (power of two, at least 2).
REQ-002 Parameter CNT_WIDTH, default 16, width of the per-channel accepted-beat counters.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-005 in_address_1 / in_address_2  input  `ADDRESS_WIDTH  beat address for channel 1 / channel 2.
REQ-006 in_id_1 / in_id_2  input  `ID_WIDTH  beat ID: [7:4] is the channel tag, [3:0] is the sequence number.
REQ-007 in_valid_1 / in_valid_2  input  1  beat present on channel 1 / channel 2.
REQ-008 out_stall_1 / out_stall_2  output  1  stall returned to the producer on channel 1 / channel 2.
REQ-009 out_address  output  `ADDRESS_WIDTH  drained beat address.
REQ-010 out_id  output  `ID_WIDTH  drained beat ID.
REQ-011 out_valid  output  1  drained beat present.
REQ-012 in_ready  input  1  downstream accepts the drained beat.
REQ-013 err_tag_1 / err_tag_2  output  1  sticky flag: tag mismatch seen on that channel.
REQ-014 err_addr_1 / err_addr_2  output  1  sticky flag: address sequence break seen on that channel.
REQ-015 count_1 / count_2  output  CNT_WIDTH  accepted-beat count per channel; wraps modulo 2^CNT_WIDTH.

Function
REQ-016 Accept rule: channel n accepts a beat in a cycle where in_valid_n==1 and out_stall_n==0; X or 0 on in_valid_n is never an accept.
REQ-017 A stalled producer holds its beat, so no beat is dropped or duplicated across stall cycles.
REQ-018 Each channel has a FIFO of FIFO_DEPTH entries holding {address, id}.
REQ-019 An accepted beat is written to its FIFO at the accepting edge.
REQ-020 Global stall: out_stall_1 = out_stall_2 = (occ_1==FIFO_DEPTH) OR (occ_2==FIFO_DEPTH), decoded combinationally from the registered occupancies only.
REQ-021 out_stall_n has no combinational path from in_valid_n or in_ready.
REQ-022 Drain is one beat per cycle, round-robin between non-empty FIFOs; the last-granted pointer toggles only on an out_valid and in_ready handshake.
REQ-023 When only one FIFO is non-empty, that FIFO is granted regardless of the pointer.
REQ-024 out_valid==1 whenever the granted FIFO is non-empty; out_address and out_id equal that FIFO's head.
REQ-025 out_valid, out_address and out_id stay stable while in_ready==0.
REQ-026 Latency: a beat accepted at edge k into empty FIFOs appears on out_valid in the cycle after edge k (1 cycle).
REQ-027 Simultaneous write and read of the same FIFO in one cycle leaves occupancy unchanged; this is legal at full and at empty.
REQ-028 Tag check: on each accept, in_id_n[7:4] != n sets err_tag_n.
REQ-029 Address check: the first accept after reset expects address 4; each later accept expects the previous accepted address +4 modulo 2^`ADDRESS_WIDTH.
REQ-030 An address mismatch sets err_addr_n; the expectation then resynchronises to the received address +4.
REQ-031 Sequence number [3:0] is not checked.
REQ-032 count_n increments on every accept and wraps from all-ones to 0.

Reset
REQ-033 On reset==0: FIFOs empty; the round-robin pointer selects channel 1 first; all err flags 0; count_n 0; expected addresses 4.
REQ-034 On reset==0: out_valid 0 and out_stall_n 0 in the following cycle.
REQ-035 Reset asserted mid-operation discards buffered beats without emitting them, and takes priority over any same-edge accept or drain.

Structure
REQ-036 `ADDRESS_WIDTH and `ID_WIDTH come from defines.vh.
REQ-037 Add channel tag constants `TAG_CH1=4'd1 and `TAG_CH2=4'd2 to defines.vh.
REQ-038 A single sub-module stall_fifo (synchronous FIFO with occupancy output) is instantiated once per channel.

Verification
REQ-039 Reset, then a producer on both channels with in_ready=1 -> output alternates ch1/ch2; address sequences 4, 8, 12 on each channel; no err flags; no stall.
REQ-040 in_ready=0, ch1 only valid -> after 4 accepts out_stall_1 = out_stall_2 = 1; raise in_ready for 1 cycle -> stall drops next cycle; exactly 5 beats accepted, no loss.
REQ-041 ch2 beat with id 8'h15 -> err_tag_2=1 and it stays 1; err_tag_1 unchanged.
REQ-042 ch1 addresses 4, 8, 16, 20 -> err_addr_1 set at 16; no new error at 20.
REQ-043 Address at 2^`ADDRESS_WIDTH-4 followed by 0 -> no err_addr; force count_1 near all-ones -> wraps to 0.
REQ-044 Assert reset with 3 beats buffered -> next cycle out_valid=0, counts 0, and the beats are never emitted.

Source files
------------

// File: rtl/stall_consumer_pkg.sv
// Types and constants shared by the stall consumer and its channel FIFOs.
`include "defines.vh"

package stall_consumer_pkg;

  localparam int ADDR_W = `ADDRESS_WIDTH;
  localparam int ID_W   = `ID_WIDTH;

  localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [ID_W-1:0]   id;
  } beat_t;

  typedef enum logic {
    CH_1 = 1'b0,
    CH_2 = 1'b1
  } chan_e;

  function automatic logic [3:0] beat_tag(input logic [ID_W-1:0] id);
    return id[7:4];
  endfunction

endpackage

// File: rtl/defines.vh
// Shared widths and channel tags for the stall consumer.
`ifndef STALL_CONSUMER_DEFINES_VH
`define STALL_CONSUMER_DEFINES_VH

`define ADDRESS_WIDTH 16
`define ID_WIDTH      8
`define TAG_CH1       4'd1
`define TAG_CH2       4'd2

`endif

// File: rtl/stall_fifo.sv
// Synchronous FIFO with occupancy output; a read and a write in the same cycle are both honoured.
module stall_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [PTR_W:0]   occ,
  output logic             empty
);

  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OCC_FULL);
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is only safe when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q];
  assign occ     = occ_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_wr, do_rd})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/stall_consumer.sv
// Two-channel beat consumer: buffers each channel, checks tags and address sequence,
// and drains both buffers round-robin to a single downstream port.
`include "defines.vh"

module stall_consumer
  import stall_consumer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    in_address_1,
  input  logic [ID_W-1:0]      in_id_1,
  input  logic                 in_valid_1,
  input  logic [ADDR_W-1:0]    in_address_2,
  input  logic [ID_W-1:0]      in_id_2,
  input  logic                 in_valid_2,
  output logic                 out_stall_1,
  output logic                 out_stall_2,
  output logic [ADDR_W-1:0]    out_address,
  output logic [ID_W-1:0]      out_id,
  output logic                 out_valid,
  input  logic                 in_ready,
  output logic                 err_tag_1,
  output logic                 err_tag_2,
  output logic                 err_addr_1,
  output logic                 err_addr_2,
  output logic [CNT_WIDTH-1:0] count_1,
  output logic [CNT_WIDTH-1:0] count_2
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  beat_t            wr_beat_1, wr_beat_2;
  beat_t            head_1, head_2, head_sel;
  logic [OCC_W-1:0] occ_1, occ_2;
  logic             empty_1, empty_2;
  logic             stall;
  logic             accept_1, accept_2;
  logic             handshake;
  logic             rd_1, rd_2;
  chan_e            grant;

  chan_e                 last_q, last_d;
  chan_e                 hold_ch_q, hold_ch_d;
  logic                  hold_q, hold_d;
  logic [ADDR_W-1:0]     exp_addr_1_q, exp_addr_1_d;
  logic [ADDR_W-1:0]     exp_addr_2_q, exp_addr_2_d;
  logic                  err_tag_1_q, err_tag_1_d;
  logic                  err_tag_2_q, err_tag_2_d;
  logic                  err_addr_1_q, err_addr_1_d;
  logic                  err_addr_2_q, err_addr_2_d;
  logic [CNT_WIDTH-1:0]  count_1_q, count_1_d;
  logic [CNT_WIDTH-1:0]  count_2_q, count_2_d;

  // Stall depends only on registered occupancy, so producers see no comb path from valid/ready.
  assign stall       = (occ_1 == OCC_FULL) || (occ_2 == OCC_FULL);
  assign out_stall_1 = stall;
  assign out_stall_2 = stall;

  assign accept_1  = in_valid_1 && !stall;
  assign accept_2  = in_valid_2 && !stall;
  assign wr_beat_1 = {in_address_1, in_id_1};
  assign wr_beat_2 = {in_address_2, in_id_2};

  stall_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(beat_t))
  ) u_fifo_1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept_1),
    .wr_data (wr_beat_1),
    .rd_en   (rd_1),
    .rd_data (head_1),
    .occ     (occ_1),
    .empty   (empty_1)
  );

  stall_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(beat_t))
  ) u_fifo_2 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept_2),
    .wr_data (wr_beat_2),
    .rd_en   (rd_2),
    .rd_data (head_2),
    .occ     (occ_2),
    .empty   (empty_2)
  );

  // A beat offered but not taken keeps its grant, so a late write to the other
  // FIFO cannot swap the presented beat while downstream is stalled.
  always_comb begin
    grant = CH_1;
    if (hold_q) begin
      grant = hold_ch_q;
    end else if (!empty_1 && !empty_2) begin
      grant = (last_q == CH_1) ? CH_2 : CH_1;
    end else if (!empty_2) begin
      grant = CH_2;
    end
  end

  assign head_sel    = (grant == CH_1) ? head_1 : head_2;
  assign out_valid   = !empty_1 || !empty_2;
  assign out_address = head_sel.address;
  assign out_id      = head_sel.id;
  assign handshake   = out_valid && in_ready;
  assign rd_1        = handshake && (grant == CH_1);
  assign rd_2        = handshake && (grant == CH_2);

  always_comb begin
    last_d       = last_q;
    hold_d       = out_valid && !in_ready;
    hold_ch_d    = grant;
    exp_addr_1_d = exp_addr_1_q;
    exp_addr_2_d = exp_addr_2_q;
    err_tag_1_d  = err_tag_1_q;
    err_tag_2_d  = err_tag_2_q;
    err_addr_1_d = err_addr_1_q;
    err_addr_2_d = err_addr_2_q;
    count_1_d    = count_1_q;
    count_2_d    = count_2_q;

    if (handshake) begin
      last_d = grant;
    end

    // After a break the expectation follows the received address, so one glitch flags once.
    if (accept_1) begin
      if (beat_tag(in_id_1) != `TAG_CH1) err_tag_1_d = 1'b1;
      if (in_address_1 != exp_addr_1_q)  err_addr_1_d = 1'b1;
      exp_addr_1_d = in_address_1 + ADDR_STEP;
      count_1_d    = count_1_q + 1'b1;
    end

    if (accept_2) begin
      if (beat_tag(in_id_2) != `TAG_CH2) err_tag_2_d = 1'b1;
      if (in_address_2 != exp_addr_2_q)  err_addr_2_d = 1'b1;
      exp_addr_2_d = in_address_2 + ADDR_STEP;
      count_2_d    = count_2_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q       <= CH_2;
      hold_q       <= 1'b0;
      hold_ch_q    <= CH_1;
      exp_addr_1_q <= ADDR_START;
      exp_addr_2_q <= ADDR_START;
      err_tag_1_q  <= 1'b0;
      err_tag_2_q  <= 1'b0;
      err_addr_1_q <= 1'b0;
      err_addr_2_q <= 1'b0;
      count_1_q    <= '0;
      count_2_q    <= '0;
    end else begin
      last_q       <= last_d;
      hold_q       <= hold_d;
      hold_ch_q    <= hold_ch_d;
      exp_addr_1_q <= exp_addr_1_d;
      exp_addr_2_q <= exp_addr_2_d;
      err_tag_1_q  <= err_tag_1_d;
      err_tag_2_q  <= err_tag_2_d;
      err_addr_1_q <= err_addr_1_d;
      err_addr_2_q <= err_addr_2_d;
      count_1_q    <= count_1_d;
      count_2_q    <= count_2_d;
    end
  end

  assign err_tag_1  = err_tag_1_q;
  assign err_tag_2  = err_tag_2_q;
  assign err_addr_1 = err_addr_1_q;
  assign err_addr_2 = err_addr_2_q;
  assign count_1    = count_1_q;
  assign count_2    = count_2_q;

endmodule
